kda_array: RTL and testbench
============================

Name: kda_array

Overview:
- Parametrised successor of the fixed 4-core KDA top.
- Accepts one PBKDF2 job as a stream of DATA_W-bit beats: a header, then the password, then the salt.
- Dispatches the job to 1..CORES external PBKDF2 cores, each computing one output block with its own block index.
- Collects results out of order and streams the derived key out, block 1 first.
- Cores sit outside this block, so benches can use stub cores.

Parameters:
- CORES, 4, number of PBKDF2 cores attached (1..8).
- DATA_W, 64, width of the input and output stream beats.
- PASS_W, 512, password width; must be a multiple of DATA_W.
- SALT_W, 512, salt width; must be a multiple of DATA_W.
- HASH_W, 256, width of one core result; must be a multiple of DATA_W.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-low reset.
- data_i  in  DATA_W  input job beats.
- v_i  in  1  input beat valid.
- ready_o  out  1  ready for an input beat.
- data_o  out  DATA_W  output key beats.
- v_o  out  1  output beat valid.
- yumi_i  in  1  consumer takes the data_o beat this cycle.
- core_v_o  out  CORES  per-core job valid.
- core_ready_i  in  CORES  per-core job ready.
- core_iters_o  out  32  shared iteration count.
- core_salt_len_o  out  6  shared salt length in bytes.
- core_pass_o  out  PASS_W  shared password.
- core_salt_o  out  SALT_W  shared salt.
- core_idx_o  out  CORES*32  block index for core i at bits [32i+:32], value i+1.
- core_v_i  in  CORES  per-core result valid.
- core_hash_i  in  CORES*HASH_W  core i result at [HASH_W*i+:HASH_W].
- core_yumi_o  out  CORES  per-core result accept.

Behaviour:
- Input handshake: a beat transfers when v_i & ready_o.
- Output handshake: a beat transfers when v_o & yumi_i; data_o is held stable while v_o=1 and yumi_i=0.
- Header beat layout:
  - [31:0] iters.
  - [37:32] salt_len.
  - [40:38] nblk-1, where nblk is the number of blocks.
  - all other bits are ignored.
- nblk clamp: if nblk-1 >= CORES, nblk = CORES.
- iters clamp: iters==0 is coerced to 1.
- Beat order after the header:
  - PASS_W/DATA_W password beats, most-significant word first.
  - then SALT_W/DATA_W salt beats, most-significant word first.
- FSM states: IDLE, LOAD, DISPATCH, WAIT, DRAIN.
  - IDLE: ready_o=1. On a header transfer, latch the header and go to LOAD.
  - LOAD: ready_o=1. Shift beats into pass/salt. After the last salt beat go to DISPATCH.
  - DISPATCH: core_v_o[i]=1 for every active core i<nblk whose sent bit is clear. Set sent[i] on core_v_o[i]&core_ready_i[i]. When all active cores are sent, go to WAIT. Cores accept in any order and any cycle.
  - WAIT (handled in DISPATCH and WAIT): core_yumi_o[i]=core_v_i[i]&sent[i]&~got[i]. On that yumi, capture the hash into slot i and set got[i]. When got covers all active cores, go to DRAIN.
  - DRAIN: emit nblk*HASH_W/DATA_W beats, slot 0 first, MS word first. On the last beat transfer go to IDLE.
- ready_o=0 outside IDLE and LOAD; back-pressure holds the current beat.
- core_v_i on an inactive or un-sent core is ignored (no yumi).
- Inactive cores: core_v_o stays 0 for the whole job.
- core_iters_o/core_salt_len_o/core_pass_o/core_salt_o: hold their values from the end of LOAD until the next header transfer.
- Latency: DISPATCH is entered the cycle after the last salt beat. With all cores ready, the job is dispatched in 1 cycle. The first v_o comes 1 cycle after the final hash capture.
- Reset (reset_i=0 at a clock edge), including mid-job:
  - FSM goes to IDLE; sent, got and beat counters clear.
  - Outputs: ready_o=0 during reset, 1 in IDLE afterwards; v_o=0; core_v_o=0; core_yumi_o=0; data_o=0.
  - Held parameter outputs are zeroed; core_idx_o is constant.
  - Results still pending in cores after reset are not owned by this block; the bench must also reset the cores.

Optional Feature:
- Macro: KDA_ARRAY_PERF_EN.
- When defined, adds output port jobs_o (32 bits): count of completed jobs, incremented on the final DRAIN beat transfer. Wraps at 2^32-1 to 0.
- When defined, adds output port busy_cycles_o (32 bits): cycles spent outside IDLE. Saturates at 2^32-1.
- Both counters clear on reset.
- When undefined, these ports and their logic are absent.

Decomposition:
- Package kda_array_pkg holds:
  - state enum kda_state_e;
  - header field offsets and widths;
  - localparams for beat counts (PASS_BEATS, SALT_BEATS, HASH_BEATS).
- One sub-module, kda_array_out_ser: the DRAIN-side serializer. It takes the slot bank and nblk, drives data_o/v_o, and handles yumi_i.

Test Plan:
- Single block: CORES=4, header nblk-1=0, iters=1000, salt_len=16; stub core 0 returns 0xAA..AA after 5 cycles -> exactly 4 beats of 0xAAAAAAAAAAAAAAAA; core_v_o[3:1] never asserted; ready_o returns to 1.
- Four blocks, results out of order: stubs finish in the order 3,1,0,2 with hash words = core index -> 16 beats in order 0,0,0,0,1,...,3; core_idx_o = 1,2,3,4.
- Staggered ready: core_ready_i raised one core per cycle (3,2,1,0) -> each core_v_o drops only after its own handshake; no double dispatch.
- Output back-pressure: yumi_i low for 10 cycles mid-drain -> data_o stable and no beats lost; v_i driven meanwhile -> ready_o=0.
- Boundaries: header iters=0 with nblk-1=7 on CORES=4 -> core_iters_o=1 and 4 cores dispatched. Reset asserted mid-WAIT -> next cycle all outputs at reset values; a fresh job then completes correctly.
- With KDA_ARRAY_PERF_EN: run 3 jobs -> jobs_o=3; busy_cycles_o equals the bench-counted non-IDLE cycles.

Source files
------------

// File: rtl/kda_array_pkg.sv
// kda_array_pkg: shared types and constants for the KDA core array.
// Holds the FSM state type, header field layout and default beat counts.
package kda_array_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DISPATCH,
        ST_WAIT,
        ST_DRAIN
    } kda_state_e;

    localparam int HDR_ITERS_LSB = 0;
    localparam int HDR_ITERS_W   = 32;
    localparam int HDR_SLEN_LSB  = 32;
    localparam int HDR_SLEN_W    = 6;
    localparam int HDR_NBLK_LSB  = 38;
    localparam int HDR_NBLK_W    = 3;

    localparam int IDX_W = 32;

    function automatic int beats(input int w, input int dw);
        return w / dw;
    endfunction

    localparam int PASS_BEATS = beats(512, 64);
    localparam int SALT_BEATS = beats(512, 64);
    localparam int HASH_BEATS = beats(256, 64);

endpackage

// File: rtl/kda_array_out_ser.sv
// kda_array_out_ser: drains the captured hash slots as DATA_W beats,
// slot 0 first and most-significant word first, under yumi flow control.
module kda_array_out_ser
    import kda_array_pkg::*;
#(
    parameter int CORES  = 4,
    parameter int DATA_W = 64,
    parameter int HASH_W = 256
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    en_i,
    input  logic [3:0]              nblk_i,
    input  logic [CORES*HASH_W-1:0] slots_i,
    input  logic                    yumi_i,
    output logic [DATA_W-1:0]       data_o,
    output logic                    v_o,
    output logic                    done_o
);

    localparam int N_HASH = beats(HASH_W, DATA_W);
    localparam int WORD_W = (N_HASH > 1) ? $clog2(N_HASH) : 1;
    localparam int SLOT_W = $clog2(CORES + 1);

    logic [WORD_W-1:0]       word_q;
    logic [SLOT_W-1:0]       slot_q;
    logic [CORES*HASH_W-1:0] sh;
    logic                    last_word;
    int                      off;

    // Select the current word out of the slot bank; idle output is zero.
    always_comb begin
        off = int'(slot_q) * HASH_W
            + (N_HASH - 1 - int'(word_q)) * DATA_W;
        sh = slots_i >> off;
        v_o = en_i;
        data_o = en_i ? sh[DATA_W-1:0] : '0;
        last_word = (word_q == WORD_W'(N_HASH - 1));
        done_o = v_o && yumi_i && last_word
              && (int'(slot_q) + 1 == int'(nblk_i));
    end

    // Advance word/slot position on each accepted beat.
    always_ff @(posedge clk_i) begin
        if (!reset_i || !en_i) begin
            word_q <= '0;
            slot_q <= '0;
        end else if (v_o && yumi_i) begin
            if (last_word) begin
                word_q <= '0;
                slot_q <= slot_q + SLOT_W'(1);
            end else begin
                word_q <= word_q + WORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/kda_array.sv
// kda_array: loads one PBKDF2 job, fans it out to CORES external cores,
// collects results out of order and streams the key. Option: KDA_ARRAY_PERF_EN.
module kda_array
    import kda_array_pkg::*;
#(
    parameter int CORES  = 4,
    parameter int DATA_W = 64,
    parameter int PASS_W = 512,
    parameter int SALT_W = 512,
    parameter int HASH_W = 256
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [DATA_W-1:0]       data_o,
    output logic                    v_o,
    input  logic                    yumi_i,
    output logic [CORES-1:0]        core_v_o,
    input  logic [CORES-1:0]        core_ready_i,
    output logic [31:0]             core_iters_o,
    output logic [5:0]              core_salt_len_o,
    output logic [PASS_W-1:0]       core_pass_o,
    output logic [SALT_W-1:0]       core_salt_o,
    output logic [CORES*32-1:0]     core_idx_o,
    input  logic [CORES-1:0]        core_v_i,
    input  logic [CORES*HASH_W-1:0] core_hash_i,
    output logic [CORES-1:0]        core_yumi_o
`ifdef KDA_ARRAY_PERF_EN
    ,
    output logic [31:0]             jobs_o,
    output logic [31:0]             busy_cycles_o
`endif
);

    localparam int N_PASS    = beats(PASS_W, DATA_W);
    localparam int N_SALT    = beats(SALT_W, DATA_W);
    localparam int LOAD_LAST = N_PASS + N_SALT - 1;
    localparam int BEAT_W    = $clog2(N_PASS + N_SALT);

    kda_state_e              state_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [3:0]              nblk_q;
    logic [31:0]             iters_q;
    logic [5:0]              salt_len_q;
    logic [PASS_W-1:0]       pass_q;
    logic [SALT_W-1:0]       salt_q;
    logic [CORES-1:0]        core_v_q;
    logic [CORES-1:0]        sent_q;
    logic [CORES-1:0]        got_q;
    logic [CORES*HASH_W-1:0] slots_q;

    logic [CORES-1:0]        act;
    logic [CORES-1:0]        hs;
    logic [CORES-1:0]        sent_d;
    logic [CORES-1:0]        got_d;
    logic                    collect;
    logic [31:0]             hdr_iters;
    logic [HDR_NBLK_W-1:0]   hdr_nb1;
    logic [3:0]              hdr_nblk;
    logic                    ser_done;

    // Header decode with the iteration and block-count clamps.
    always_comb begin
        hdr_iters = data_i[HDR_ITERS_LSB +: HDR_ITERS_W];
        if (hdr_iters == 32'd0) begin
            hdr_iters = 32'd1;
        end
        hdr_nb1 = data_i[HDR_NBLK_LSB +: HDR_NBLK_W];
        if (int'(hdr_nb1) >= CORES) begin
            hdr_nblk = 4'(CORES);
        end else begin
            hdr_nblk = {1'b0, hdr_nb1} + 4'd1;
        end
    end

    // Active-core mask, handshakes and result-accept strobes.
    always_comb begin
        act = '0;
        for (int i = 0; i < CORES; i++) begin
            act[i] = (i < int'(nblk_q));
        end
        collect = (state_q == ST_DISPATCH) || (state_q == ST_WAIT);
        hs = core_v_q & core_ready_i;
        core_yumi_o = '0;
        if (collect) begin
            core_yumi_o = core_v_i & sent_q & ~got_q & act;
        end
        sent_d = sent_q | hs;
        got_d = got_q | core_yumi_o;
    end

    assign ready_o = reset_i
        && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
    assign core_v_o        = core_v_q;
    assign core_iters_o    = iters_q;
    assign core_salt_len_o = salt_len_q;
    assign core_pass_o     = pass_q;
    assign core_salt_o     = salt_q;

    for (genvar g = 0; g < CORES; g++) begin : g_idx
        assign core_idx_o[IDX_W*g +: IDX_W] = IDX_W'(g + 1);
    end

    // Job FSM: load, dispatch, collect, drain.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            nblk_q     <= 4'd1;
            iters_q    <= '0;
            salt_len_q <= '0;
            pass_q     <= '0;
            salt_q     <= '0;
            core_v_q   <= '0;
            sent_q     <= '0;
            got_q      <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (v_i && ready_o) begin
                        iters_q    <= hdr_iters;
                        salt_len_q <= data_i[HDR_SLEN_LSB +: HDR_SLEN_W];
                        nblk_q     <= hdr_nblk;
                        beat_q     <= '0;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (v_i) begin
                        if (beat_q < BEAT_W'(N_PASS)) begin
                            pass_q <= PASS_W'({pass_q, data_i});
                        end else begin
                            salt_q <= SALT_W'({salt_q, data_i});
                        end
                        if (beat_q == BEAT_W'(LOAD_LAST)) begin
                            beat_q   <= '0;
                            sent_q   <= '0;
                            got_q    <= '0;
                            core_v_q <= act;
                            state_q  <= ST_DISPATCH;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                end
                ST_DISPATCH: begin
                    sent_q   <= sent_d;
                    got_q    <= got_d;
                    core_v_q <= core_v_q & ~hs;
                    if (sent_d == act) begin
                        state_q <= (got_d == act) ? ST_DRAIN : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    got_q <= got_d;
                    if (got_d == act) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (ser_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Capture each accepted core result into its slot.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            slots_q <= '0;
        end else if (collect) begin
            for (int i = 0; i < CORES; i++) begin
                if (core_yumi_o[i]) begin
                    slots_q[i*HASH_W +: HASH_W] <=
                        core_hash_i[i*HASH_W +: HASH_W];
                end
            end
        end
    end

    kda_array_out_ser #(
        .CORES  (CORES),
        .DATA_W (DATA_W),
        .HASH_W (HASH_W)
    ) u_ser (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (state_q == ST_DRAIN),
        .nblk_i  (nblk_q),
        .slots_i (slots_q),
        .yumi_i  (yumi_i),
        .data_o  (data_o),
        .v_o     (v_o),
        .done_o  (ser_done)
    );

`ifdef KDA_ARRAY_PERF_EN
    logic [31:0] jobs_q;
    logic [31:0] busy_q;

    // Completed-job count (wrapping) and saturating busy-cycle count.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            jobs_q <= '0;
            busy_q <= '0;
        end else begin
            if (ser_done) begin
                jobs_q <= jobs_q + 32'd1;
            end
            if (state_q != ST_IDLE && busy_q != 32'hFFFF_FFFF) begin
                busy_q <= busy_q + 32'd1;
            end
        end
    end

    assign jobs_o        = jobs_q;
    assign busy_cycles_o = busy_q;
`endif

endmodule

// File: tb/tb_kda_array.sv
// tb_kda_array: directed bench for kda_array with stub PBKDF2 cores.
// Stub cores return bench-chosen hash words after a per-core delay.
module tb_kda_array;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic [63:0]    data_i;
    logic           v_i;
    logic           ready_o;
    logic [63:0]    data_o;
    logic           v_o;
    logic           yumi_i;
    logic [3:0]     core_v_o;
    logic [3:0]     core_ready_i;
    logic [31:0]    core_iters_o;
    logic [5:0]     core_salt_len_o;
    logic [511:0]   core_pass_o;
    logic [511:0]   core_salt_o;
    logic [127:0]   core_idx_o;
    logic [3:0]     core_v_i;
    logic [1023:0]  core_hash_i;
    logic [3:0]     core_yumi_o;
`ifdef KDA_ARRAY_PERF_EN
    logic [31:0]    jobs_o;
    logic [31:0]    busy_cycles_o;
`endif

    kda_array dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .data_i          (data_i),
        .v_i             (v_i),
        .ready_o         (ready_o),
        .data_o          (data_o),
        .v_o             (v_o),
        .yumi_i          (yumi_i),
        .core_v_o        (core_v_o),
        .core_ready_i    (core_ready_i),
        .core_iters_o    (core_iters_o),
        .core_salt_len_o (core_salt_len_o),
        .core_pass_o     (core_pass_o),
        .core_salt_o     (core_salt_o),
        .core_idx_o      (core_idx_o),
        .core_v_i        (core_v_i),
        .core_hash_i     (core_hash_i),
        .core_yumi_o     (core_yumi_o)
`ifdef KDA_ARRAY_PERF_EN
        ,
        .jobs_o          (jobs_o),
        .busy_cycles_o   (busy_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          h_cyc = 0;
    int          busy_exp = 0;
    int          jobs_exp = 0;
    int          dly [4];
    int          cnt [4];
    int          disp [4];
    int          snap [4];
    logic [3:0]  busy;
    logic [63:0] hw [4][4];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Stub cores: accept a job, wait dly cycles, offer the hash until taken.
    always @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset_i) begin
                busy[i]     <= 1'b0;
                cnt[i]      <= 0;
                core_v_i[i] <= 1'b0;
            end else if (core_v_o[i] && core_ready_i[i]) begin
                busy[i] <= 1'b1;
                cnt[i]  <= dly[i];
                disp[i] <= disp[i] + 1;
            end else if (busy[i] && !core_v_i[i]) begin
                if (cnt[i] == 0) core_v_i[i] <= 1'b1;
                else cnt[i] <= cnt[i] - 1;
            end else if (core_v_i[i] && core_yumi_o[i]) begin
                core_v_i[i] <= 1'b0;
                busy[i]     <= 1'b0;
            end
        end
    end

    always_comb begin
        core_hash_i = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                core_hash_i[i*256 + (3-j)*64 +: 64] = hw[i][j];
    end

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input logic [31:0] it,
                                           input logic [5:0] sl,
                                           input logic [2:0] nb1);
        return {23'h7F_FFFF, nb1, sl, it};
    endfunction

    function automatic logic [511:0] mk_words(input logic [31:0] seed);
        logic [511:0] r = '0;
        for (int k = 0; k < 8; k++) r = {r[447:0], seed, 32'(k)};
        return r;
    endfunction

    task automatic put(input logic [63:0] beat);
        int n = 0;
        data_i = beat;
        v_i = 1'b1;
        while (!ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("rdy_wait", 1'(n < 50), 1'b1);
        @(negedge clk_i);
        v_i = 1'b0;
    endtask

    task automatic send_job(input logic [63:0] hdr, input logic [31:0] seed);
        for (int i = 0; i < 4; i++) snap[i] = disp[i];
        put(hdr);
        h_cyc = cyc;
        for (int k = 0; k < 8; k++) put({seed, 32'(k)});
        for (int k = 0; k < 8; k++) put({~seed, 32'(k)});
    endtask

    task automatic drain(input int nb, input int bp);
        int n;
        yumi_i = 1'b1;
        for (int k = 0; k < nb * 4; k++) begin
            n = 0;
            while (!v_o && n < 200) begin
                @(negedge clk_i);
                n++;
            end
            chk("vo_wait", 1'(n < 200), 1'b1);
            chk("beat", data_o, hw[k/4][k%4]);
            if (k == bp) begin
                yumi_i = 1'b0;
                v_i = 1'b1;
                data_i = '1;
                repeat (10) begin
                    @(negedge clk_i);
                    chk("bp_data", data_o, hw[k/4][k%4]);
                    chk("bp_v", v_o, 1'b1);
                    chk("bp_rdy", ready_o, 1'b0);
                end
                v_i = 1'b0;
                yumi_i = 1'b1;
            end
            @(negedge clk_i);
        end
        yumi_i = 1'b0;
        busy_exp += cyc - h_cyc;
        jobs_exp++;
        chk("rdy_back", ready_o, 1'b1);
        chk("v_off", v_o, 1'b0);
    endtask

    task automatic chk_disp(input int nb);
        for (int i = 0; i < 4; i++)
            chk("disp", 32'(disp[i] - snap[i]), 32'(i < nb ? 1 : 0));
    endtask

    task automatic set_hw(input logic [31:0] tag);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                hw[i][j] = {tag, 16'(i), 16'(j)};
    endtask

    task automatic chk_rst();
        chk("rst_rdy", ready_o, 1'b0);
        chk("rst_v", v_o, 1'b0);
        chk("rst_cv", core_v_o, 4'h0);
        chk("rst_yumi", core_yumi_o, 4'h0);
        chk("rst_data", data_o, 64'h0);
        chk("rst_iters", core_iters_o, 32'h0);
        chk("rst_slen", core_salt_len_o, 6'h0);
        chk("rst_pass", core_pass_o, 512'h0);
        chk("rst_salt", core_salt_o, 512'h0);
        chk("idx", core_idx_o, {32'd4, 32'd3, 32'd2, 32'd1});
    endtask

    initial begin
        reset_i = 1'b0;
        v_i = 1'b0;
        data_i = '0;
        yumi_i = 1'b0;
        core_ready_i = 4'h0;
        for (int i = 0; i < 4; i++) begin
            dly[i] = 1;
            disp[i] = 0;
        end
        set_hw(32'h0);
        repeat (3) @(negedge clk_i);
        chk_rst();
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("rdy_idle", ready_o, 1'b1);

        // single block
        core_ready_i = 4'hF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                hw[i][j] = 64'hAAAA_AAAA_AAAA_AAAA;
        dly[0] = 4;
        send_job(mk_hdr(32'd1000, 6'd16, 3'd0), 32'h1234_5678);
        chk("t1_cv", core_v_o, 4'b0001);
        chk("t1_iters", core_iters_o, 32'd1000);
        chk("t1_slen", core_salt_len_o, 6'd16);
        chk("t1_pass", core_pass_o, mk_words(32'h1234_5678));
        chk("t1_salt", core_salt_o, mk_words(~32'h1234_5678));
        drain(1, -1);
        chk_disp(1);

        // four blocks, finishing 3,1,0,2
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                hw[i][j] = 64'(i);
        dly[0] = 6; dly[1] = 3; dly[2] = 9; dly[3] = 0;
        send_job(mk_hdr(32'd7, 6'd32, 3'd3), 32'hCAFE_0001);
        chk("t2_cv", core_v_o, 4'hF);
        @(negedge clk_i);
        chk("t2_cv1", core_v_o, 4'h0);
        chk("t2_idx", core_idx_o, {32'd4, 32'd3, 32'd2, 32'd1});
        drain(4, -1);
        chk_disp(4);

        // staggered ready plus output back-pressure
        core_ready_i = 4'h0;
        set_hw(32'hC0DE_0003);
        for (int i = 0; i < 4; i++) dly[i] = 2;
        send_job(mk_hdr(32'd3, 6'd8, 3'd3), 32'h5A5A_0003);
        chk("t3_cv0", core_v_o, 4'hF);
        @(negedge clk_i);
        chk("t3_cv1", core_v_o, 4'hF);
        core_ready_i[3] = 1'b1;
        @(negedge clk_i);
        chk("t3_cv2", core_v_o, 4'b0111);
        core_ready_i[2] = 1'b1;
        @(negedge clk_i);
        chk("t3_cv3", core_v_o, 4'b0011);
        core_ready_i[1] = 1'b1;
        @(negedge clk_i);
        chk("t3_cv4", core_v_o, 4'b0001);
        core_ready_i[0] = 1'b1;
        @(negedge clk_i);
        chk("t3_cv5", core_v_o, 4'b0000);
        drain(4, 5);
        chk_disp(4);

        // iters=0 and nblk-1 above CORES
        set_hw(32'hB0B0_0005);
        for (int i = 0; i < 4; i++) dly[i] = i;
        send_job(mk_hdr(32'd0, 6'd5, 3'd7), 32'h0BAD_F00D);
        chk("t5_iters", core_iters_o, 32'd1);
        chk("t5_slen", core_salt_len_o, 6'd5);
        chk("t5_cv", core_v_o, 4'hF);
        drain(4, -1);
        chk_disp(4);

        // reset in the middle of WAIT
        for (int i = 0; i < 4; i++) dly[i] = 30;
        send_job(mk_hdr(32'd9, 6'd1, 3'd3), 32'h7777_0006);
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk_rst();
        busy_exp = 0;
        jobs_exp = 0;
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("t6_rdy", ready_o, 1'b1);
        chk("t6_v", v_o, 1'b0);

        for (int i = 0; i < 4; i++) dly[i] = 2;
        set_hw(32'hF00D_0006);
        send_job(mk_hdr(32'd2, 6'd3, 3'd1), 32'h1357_9BDF);
        chk("t6_pass", core_pass_o, mk_words(32'h1357_9BDF));
        drain(2, -1);
        chk_disp(2);
        set_hw(32'hF00D_0007);
        send_job(mk_hdr(32'd4, 6'd4, 3'd2), 32'h2468_ACE0);
        drain(3, -1);
        chk_disp(3);
        set_hw(32'hF00D_0008);
        send_job(mk_hdr(32'd5, 6'd6, 3'd0), 32'h0F0F_0F0F);
        drain(1, 0);
        chk_disp(1);
`ifdef KDA_ARRAY_PERF_EN
        chk("jobs", jobs_o, 32'(jobs_exp));
        chk("busy", busy_cycles_o, 32'(busy_exp));
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
